// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one combinational ALU between two requesters.
// Optional per-requester sticky overflow is built when ALU_SCHED_STICKY_OVF_EN is defined.
module alu_sched #(
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0][3:0]        req_op_i,
  input  logic [1:0][DATA_W-1:0] req_a_i,
  input  logic [1:0][DATA_W-1:0] req_b_i,
  output logic [1:0]             rsp_valid_o,
  input  logic [1:0]             rsp_ready_i,
  output logic [DATA_W-1:0]      rsp_out_o,
  output logic                   rsp_zero_o,
  output logic                   rsp_neg_o,
  output logic                   rsp_ovf_o,
  output logic [3:0]             alu_op_o,
  output logic [DATA_W-1:0]      alu_a_o,
  output logic [DATA_W-1:0]      alu_b_o,
  input  logic [DATA_W-1:0]      alu_out_i,
  input  logic                   alu_zero_i,
  input  logic                   alu_neg_i,
  input  logic                   alu_ovf_i,
  output logic [1:0]             ovf_sticky_o,
  input  logic [1:0]             ovf_clr_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;

  logic gnt_sel;
  logic req_hs;
  logic rsp_hs;

  // Requester 1 wins when it is the only one asking, or on a tie when 0 was served last.
  assign gnt_sel = req_valid_i[1] & (~req_valid_i[0] | ~last_q);

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ready_o[gi] = (state_q == S_IDLE) & ~rst_i & req_valid_i[gi] & (gnt_sel == 1'(gi));
    assign rsp_valid_o[gi] = (state_q == S_RESP) & (gnt_q == 1'(gi));
  end

  assign req_hs = |req_ready_o;
  assign rsp_hs = (state_q == S_RESP) & rsp_ready_i[gnt_q];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (req_hs) begin
          gnt_d   = gnt_sel;
          op_d    = req_op_i[gnt_sel];
          a_d     = req_a_i[gnt_sel];
          b_d     = req_b_i[gnt_sel];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_out_i;
        zero_d  = alu_zero_i;
        neg_d   = alu_neg_i;
        ovf_d   = alu_ovf_i;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_hs) begin
          last_d  = gnt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign alu_op_o   = op_q;
  assign alu_a_o    = a_q;
  assign alu_b_o    = b_q;
  assign rsp_out_o  = res_q;
  assign rsp_zero_o = zero_q;
  assign rsp_neg_o  = neg_q;
  assign rsp_ovf_o  = ovf_q;

`ifdef ALU_SCHED_STICKY_OVF_EN
  logic [1:0] sticky_q, sticky_d;

  // A clear in the capture cycle overrides the set for the same requester.
  always_comb begin
    sticky_d = sticky_q;
    for (int i = 0; i < 2; i++) begin
      if ((state_q == S_EXEC) && (gnt_q == 1'(i)) && alu_ovf_i) sticky_d[i] = 1'b1;
      if (ovf_clr_i[i]) sticky_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign ovf_sticky_o = sticky_q;
`else
  logic unused_clr;
  assign unused_clr   = ^ovf_clr_i;
  assign ovf_sticky_o = '0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scoreboard bench for alu_sched with a behavioural ALU and a queue-based reference model.
module tb_alu_sched;

  localparam int DW = 32;
`ifdef ALU_SCHED_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8, OP_SLTU = 4'd9;

  typedef struct packed {
    logic [DW-1:0] out;
    logic          z;
    logic          n;
    logic          v;
  } res_t;

  typedef struct {
    bit        req;
    logic [3:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    res_t      r;
    int        acc_cyc;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready, ovf_sticky, ovf_clr;
  logic [1:0][3:0] req_op;
  logic [1:0][DW-1:0] req_a, req_b;
  logic [DW-1:0] rsp_out, alu_a, alu_b, alu_out;
  logic rsp_zero, rsp_neg, rsp_ovf, alu_zero, alu_neg, alu_ovf;
  logic [3:0] alu_op;

  always #5 clk = ~clk;

  alu_sched #(.DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_out_o(rsp_out), .rsp_zero_o(rsp_zero), .rsp_neg_o(rsp_neg), .rsp_ovf_o(rsp_ovf),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_out_i(alu_out), .alu_zero_i(alu_zero), .alu_neg_i(alu_neg), .alu_ovf_i(alu_ovf),
    .ovf_sticky_o(ovf_sticky), .ovf_clr_i(ovf_clr)
  );

  // Behavioural ALU: shifts move B by A[4:0], unknown opcodes give 0.
  function automatic res_t alu_ref(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    res_t r;
    r.v = 1'b0;
    case (op)
      OP_ADD:  begin r.out = a + b; r.v = (a[DW-1] == b[DW-1]) && (r.out[DW-1] != a[DW-1]); end
      OP_SUB:  begin r.out = a - b; r.v = (a[DW-1] != b[DW-1]) && (r.out[DW-1] != a[DW-1]); end
      OP_AND:  r.out = a & b;
      OP_OR:   r.out = a | b;
      OP_XOR:  r.out = a ^ b;
      OP_SLL:  r.out = b << a[4:0];
      OP_SRL:  r.out = b >> a[4:0];
      OP_SRA:  r.out = $unsigned($signed(b) >>> a[4:0]);
      OP_SLT:  r.out = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_SLTU: r.out = (a < b) ? 1 : 0;
      default: r.out = '0;
    endcase
    r.z = (r.out == '0);
    r.n = r.out[DW-1];
    return r;
  endfunction

  res_t alu_r;
  always_comb alu_r = alu_ref(alu_op, alu_a, alu_b);
  assign alu_out  = alu_r.out;
  assign alu_zero = alu_r.z;
  assign alu_neg  = alu_r.n;
  assign alu_ovf  = alu_r.v;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  txn_t sb[$];
  bit [1:0] pend = '0;
  logic [3:0] pop [2];
  logic [DW-1:0] pa [2], pb [2];
  bit auto_gen = 1'b0;
  bit rst_req = 1'b1;
  logic [1:0] clr_req = '0;
  int bp_hold = 0;

  bit m_busy = 1'b0, m_exec = 1'b0, m_last = 1'b1;
  bit acc_hs = 1'b0, rsp_hs = 1'b0;
  logic [1:0] sticky_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    pend[i] = 1'b1;
    pop[i] = op;
    pa[i] = a;
    pb[i] = b;
  endtask

  // One cycle of request-side stimulus plus the expected grant from the reference model.
  task automatic drive_cycle();
    logic [1:0] exp_rdy;
    bit g;
    txn_t t;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (auto_gen && !pend[i] && $urandom_range(0, 2) == 0)
        set_req(i, 4'($urandom_range(0, 11)), rand_word(), rand_word());
    end
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = pend[i];
      req_op[i] = pop[i];
      req_a[i] = pa[i];
      req_b[i] = pb[i];
    end
    ovf_clr = clr_req;
    if (auto_gen && $urandom_range(0, 7) == 0) ovf_clr = ovf_clr | 2'($urandom_range(1, 3));
    clr_req = '0;
    rst = rst_req;
    #1;
    exp_rdy = '0;
    g = 1'b0;
    if (!rst && !m_busy && pend != 2'b00) begin
      g = (pend == 2'b11) ? ~m_last : pend[1];
      exp_rdy[g] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      t.req = g; t.op = pop[g]; t.a = pa[g]; t.b = pb[g];
      t.r = alu_ref(pop[g], pa[g], pb[g]);
      t.acc_cyc = cyc;
      sb.push_back(t);
      pend[g] = 1'b0;
      acc_hs = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((pend != 2'b00 || sb.size() != 0) && n < budget) begin
      drive_cycle();
      n++;
    end
    if (pend != 2'b00 || sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle_timeout: pend=%b outstanding=%0d after %0d cycles", pend, sb.size(), budget);
    end
  endtask

  task automatic wait_accept(input int i, input int budget);
    int n = 0;
    while (pend[i] && n < budget) begin
      drive_cycle();
      n++;
    end
    if (pend[i]) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: req%0d not accepted within %0d cycles", i, budget);
    end
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    run(2);
    rst_req = 1'b0;
  endtask

  // Reference model state advances on the same edge the DUT samples.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0; m_exec = 1'b0; m_last = 1'b1;
      sticky_exp = '0;
      sb.delete();
    end else begin
      if (m_exec) begin
        m_exec = 1'b0;
        if (STICKY && sb.size() > 0 && sb[0].r.v) sticky_exp[sb[0].req] = 1'b1;
      end
      if (STICKY) sticky_exp = sticky_exp & ~ovf_clr;
      if (rsp_hs && sb.size() > 0) begin
        m_busy = 1'b0;
        m_last = sb[0].req;
        void'(sb.pop_front());
      end
      if (acc_hs) begin
        m_busy = 1'b1;
        m_exec = 1'b1;
      end
    end
    acc_hs = 1'b0;
    rsp_hs = 1'b0;
  end

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    logic [1:0] exp_v, rr;
    rsp_ready = '0;
    forever begin
      @(negedge clk);
      #2;
      exp_v = '0;
      if (sb.size() > 0 && cyc >= sb[0].acc_cyc + 2) exp_v[sb[0].req] = 1'b1;
      check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (exp_v != 2'b00) begin
        check("rsp_out", 64'(rsp_out), 64'(sb[0].r.out));
        check("rsp_zero", 64'(rsp_zero), 64'(sb[0].r.z));
        check("rsp_neg", 64'(rsp_neg), 64'(sb[0].r.n));
        check("rsp_ovf", 64'(rsp_ovf), 64'(sb[0].r.v));
      end
      check("ovf_sticky", 64'(ovf_sticky), 64'(sticky_exp));
      rr = 2'($urandom_range(0, 3));
      if (exp_v != 2'b00 && bp_hold > 0) begin
        rr = '0;
        bp_hold--;
      end
      rsp_ready = rr;
      if (exp_v != 2'b00 && rr[sb[0].req]) begin
        rsp_hs = 1'b1;
        $display("[TB] rsp req%0d op=%0d a=%h b=%h -> out=%h z=%0d n=%0d v=%0d",
                 sb[0].req, sb[0].op, sb[0].a, sb[0].b, rsp_out, rsp_zero, rsp_neg, rsp_ovf);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; ovf_clr = '0;
    for (int i = 0; i < 2; i++) begin pop[i] = '0; pa[i] = '0; pb[i] = '0; end

    do_reset();
    check("reset_rsp_out", 64'(rsp_out), 64'd0);
    check("reset_flags", 64'({rsp_zero, rsp_neg, rsp_ovf}), 64'd0);
    check("reset_alu_op", 64'(alu_op), 64'd0);
    check("reset_alu_ab", {alu_a, alu_b}, 64'd0);
    check("reset_sticky", 64'(ovf_sticky), 64'd0);

    // Single request
    set_req(0, OP_ADD, 32'd5, 32'd7);
    wait_idle(50);

    // Tie after reset, then alternating grants with both requesters busy
    do_reset();
    set_req(0, OP_SUB, 32'd3, 32'd3);
    set_req(1, OP_OR, 32'h0000_00F0, 32'h0000_000F);
    wait_idle(50);
    for (int k = 0; k < 2; k++) begin
      set_req(0, OP_XOR, rand_word(), rand_word());
      set_req(1, OP_ADD, rand_word(), rand_word());
      wait_idle(50);
    end

    // Back-pressure on requester 1 while requester 0 waits
    set_req(1, OP_AND, $urandom, $urandom);
    bp_hold = 5;
    wait_accept(1, 20);
    set_req(0, OP_SRA, 32'd4, 32'h8000_0010);
    wait_idle(60);

    // Overflow, sticky hold, clear, and clear coinciding with set
    set_req(1, OP_SUB, 32'h8000_0000, 32'd1);
    wait_idle(50);
    run(3);
    clr_req = 2'b10;
    run(2);
    set_req(1, OP_SUB, 32'h8000_0000, 32'd1);
    wait_accept(1, 20);
    clr_req = 2'b10;
    wait_idle(50);
    run(2);

    // Reset while an operation is in EXEC
    set_req(0, OP_ADD, 32'd1, 32'd2);
    wait_idle(50);
    set_req(1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    wait_accept(1, 20);
    rst_req = 1'b1;
    drive_cycle();
    rst_req = 1'b0;
    run(4);
    set_req(0, OP_SLL, 32'd4, 32'd1);
    set_req(1, OP_SRL, 32'd4, 32'h100);
    wait_idle(50);

    // Signed and unsigned compares
    set_req(0, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    wait_idle(50);
    set_req(1, OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    wait_idle(50);
    set_req(0, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    set_req(1, 4'd13, $urandom, $urandom);
    wait_idle(50);

    // Randomized traffic
    auto_gen = 1'b1;
    run(400);
    auto_gen = 1'b0;
    wait_idle(200);
    run(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler that shares a single combinational ALU (aluop_t encoding from cpu_types_pkg) between two clients, e.g. two cores' execute stages or a core plus a debug port. Operations are accepted over per-requester valid/ready handshakes, arbitrated round-robin, launched into the ALU from registered operands, and returned with registered result and flags. Only one operation is in flight at a time.

## Interface
- DATA_W, 32, operand/result width; must match the ALU
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  reset; synchronous, active-high
- req_valid  in  2  per-requester operation valid
- req_ready  out  2  per-requester accept; at most one bit set
- req_op  in  2x4  per-requester aluop_t
- req_a, req_b  in  2xDATA_W  per-requester operands A and B
- rsp_valid  out  2  per-requester result valid; at most one bit set
- rsp_ready  in  2  per-requester result accept
- rsp_out  out  DATA_W  result, shared by both requesters
- rsp_zero, rsp_neg, rsp_ovf  out  1 each  registered ALU flags
- alu_op  out  4  to ALU aluop
- alu_a, alu_b  out  DATA_W  to ALU port_a, port_b
- alu_out  in  DATA_W  from ALU port_out
- alu_zero, alu_neg, alu_ovf  in  1 each  from ALU zero, negative, overflow
- ovf_sticky  out  2  per-requester sticky overflow (see Configuration)
- ovf_clr  in  2  per-requester sticky clear

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = requester with req_valid set. If both are set, g = the requester that was not last served (round-robin pointer `last`).
  - req_ready[g] = 1 combinationally; the other bit is 0.
  - On the handshake, latch op, A, B and g; go to EXEC.
  - If neither req_valid is set, stay in IDLE.
- EXEC:
  - alu_op/alu_a/alu_b are driven from the latched registers.
  - Capture alu_out and all flags into the result registers; go to RESP.
- RESP:
  - rsp_valid[g] = 1; hold result and flags stable.
  - On rsp_ready[g]: set `last` = g and go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- req_ready is 0 in EXEC and RESP. A requester may hold req_valid across these states; operands are sampled only at the handshake.
- ALU outputs are driven from the latched registers in all states; values outside EXEC are don't-care to the ALU.
- Arithmetic and flags are exactly the ALU's: SUB computes A−B, SLT/SLTU yield 0/1, shifts use A[4:0] as amount, undefined op yields 0. This block does no arithmetic of its own.

## Timing
- Accept in cycle N (IDLE handshake), EXEC in N+1, rsp_valid high from N+2.
- Minimum accept-to-accept spacing is 3 cycles. Back-pressure on rsp_ready extends RESP indefinitely.
- Response handshake in cycle M: the next request can be accepted in M+1 at the earliest.
- Reset values: FSM=IDLE; `last`=1, so requester 0 wins the first tie. req_ready=0 during the reset cycle. rsp_valid=0; rsp_out=0; all rsp flags 0; latched op/operands 0; ovf_sticky=0.
- RST asserted in any state takes effect at the next edge and wins over all other events. An in-flight operation is dropped with no response and no sticky update.
- Simultaneous sticky set (RESP capture with overflow) and ovf_clr on the same requester in the same cycle: clear wins.

## Configuration
- Macro: ALU_SCHED_STICKY_OVF_EN.
- Defined:
  - When a result with rsp_ovf=1 is captured (EXEC→RESP), ovf_sticky[g] is set.
  - It stays set until ovf_clr[g] or RST.
- Undefined:
  - ovf_sticky is tied to 0 and ovf_clr is ignored.
  - No sticky flops are built.
  - Per-op rsp_ovf is unaffected.

## Test plan
- Single request: req0 ADD A=5, B=7 → req_ready[0] in cycle N; rsp_valid[0] in N+2 with rsp_out=12, zero=0, neg=0, ovf=0.
- Tie and fairness: both valid after reset (req0 SUB 3−3, req1 OR 0xF0|0x0F) → req0 served first (rsp_out=0, zero=1), then req1 (rsp_out=0xFF). With both still valid, the grants alternate 0,1,0,1.
- Back-pressure: rsp_ready[1] held low 5 cycles → rsp_valid[1] and rsp_out stay stable; req_ready stays 0 for the entire RESP period.
- Overflow: req1 SUB A=0x80000000, B=1 → rsp_out=0x7FFFFFFF, ovf=1. With the macro defined, ovf_sticky[1]=1 until ovf_clr[1]; clear and set in the same cycle leaves it 0. Without the macro, ovf_sticky stays 0.
- Reset mid-op: RST in the EXEC cycle → no rsp_valid afterwards; state is IDLE and the next tie is granted to req0.
- Flag ops: SLT A=−1, B=1 → rsp_out=1; SLTU with the same operands → rsp_out=0, zero=1.
